soma_sched: RTL and testbench

Per-timestep sweep controller for the soma neuron-state memory. On each timestep pulse it walks neuron addresses 0..`neuron_last`, driving the soma's `config_soma_vld`/`config_soma_vm_addr`/`config_soma_clear` strobes one address per cycle. It arbitrates soma memory ports against axon writes and host config access, and captures the soma's fire outputs into a small spike-address FIFO with a valid/ready output. It sits between the node timestep controller and the soma, and feeds the spike-out packetizer.

---
 rtl/soma_sched.sv | 161 ++++++++++++++++
 tb/tb_soma_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/soma_sched.sv
// Per-timestep sweep controller for the soma neuron-state memory: walks neuron
// addresses, arbitrates soma access, and queues fired addresses for the packetizer.
module soma_sched #(
  parameter int NNW       = 12,
  parameter int SPK_DEPTH = 4
) (
  input  logic           clk_soma,
  input  logic           rst_n,
  input  logic           enable,
  input  logic           tick_start,
  input  logic           clear_mode,
  input  logic [NNW-1:0] neuron_last,
  input  logic           axon_busy,
  input  logic           cfg_req,
  output logic           cfg_gnt,
  input  logic           soma_spk_out_fire,
  output logic           config_soma_vld,
  output logic [NNW-1:0] config_soma_vm_addr,
  output logic           config_soma_clear,
  output logic           spk_vld,
  output logic [NNW-1:0] spk_addr,
  input  logic           spk_rdy,
  output logic           busy,
  output logic           tick_done,
  output logic           tick_overrun
);
  localparam int PW = $clog2(SPK_DEPTH);
  localparam int CW = $clog2(SPK_DEPTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, DRAIN = 2'd2} state_t;

  // Spike output handshake: a head entry transfers in any cycle where
  // spk_vld and spk_rdy are both high; spk_addr is stable while spk_vld waits.
  state_t         state;
  logic [NNW-1:0] cnt;
  logic [NNW-1:0] last_q;
  logic           clear_q;
  logic           pending;
  logic           vld_d;
  logic           clear_d;
  logic [NNW-1:0] addr_d;
  logic [NNW-1:0] mem [SPK_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [CW:0]    occ;
  logic           room;
  logic           start_go;
  logic           start_clear;
  logic [NNW-1:0] start_last;
  logic           push;
  logic           pop;

  // Both the strobe on the wire and its delayed copy may still push, so both
  // are reserved before another address is issued.
  assign occ = {1'b0, count} + {{CW{1'b0}}, config_soma_vld} + {{CW{1'b0}}, vld_d};
  assign room = !axon_busy && (occ <= (CW+1)'(SPK_DEPTH - 1));
  assign start_go = (tick_start || pending) && !cfg_req;
  assign start_clear = pending ? clear_q : clear_mode;
  assign start_last = pending ? last_q : neuron_last;
  assign push = vld_d && !clear_d && soma_spk_out_fire;
  assign pop = spk_vld && spk_rdy;
  assign busy = (state != IDLE);
  assign cfg_gnt = (state == IDLE) && cfg_req;
  assign spk_vld = (count != '0);
  assign spk_addr = mem[rd_ptr];

  always_ff @(posedge clk_soma or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      last_q <= '0;
      clear_q <= 1'b0;
      pending <= 1'b0;
      config_soma_vld <= 1'b0;
      config_soma_vm_addr <= '0;
      config_soma_clear <= 1'b0;
      vld_d <= 1'b0;
      addr_d <= '0;
      clear_d <= 1'b0;
      tick_done <= 1'b0;
      tick_overrun <= 1'b0;
    end else begin
      config_soma_vld <= 1'b0;
      tick_done <= 1'b0;
      tick_overrun <= 1'b0;
      vld_d <= config_soma_vld;
      addr_d <= config_soma_vm_addr;
      clear_d <= config_soma_clear;
      if (!enable) begin
        state <= IDLE;
        pending <= 1'b0;
        cnt <= '0;
        vld_d <= 1'b0;
      end else begin
        tick_overrun <= tick_start && ((state != IDLE) || pending);
        case (state)
          IDLE: begin
            if (start_go) begin
              // The first address issues straight from IDLE to save a cycle.
              pending <= 1'b0;
              clear_q <= start_clear;
              last_q <= start_last;
              state <= SWEEP;
              cnt <= '0;
              if (room) begin
                config_soma_vld <= 1'b1;
                config_soma_vm_addr <= '0;
                config_soma_clear <= start_clear;
                cnt <= {{(NNW-1){1'b0}}, 1'b1};
                if (start_last == '0) state <= DRAIN;
              end
            end else if (tick_start && !pending) begin
              pending <= 1'b1;
              clear_q <= clear_mode;
              last_q <= neuron_last;
            end
          end
          SWEEP: begin
            if (room) begin
              config_soma_vld <= 1'b1;
              config_soma_vm_addr <= cnt;
              config_soma_clear <= clear_q;
              cnt <= cnt + 1'b1;
              if (cnt == last_q) state <= DRAIN;
            end
          end
          DRAIN: begin
            // Leave once the final strobe has moved on to the capture stage.
            if (!config_soma_vld) begin
              state <= IDLE;
              tick_done <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_soma or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < SPK_DEPTH; i++) mem[i] <= '0;
    end else if (!enable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= addr_d;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end
endmodule

// File: tb/tb_soma_sched.sv
// Bench for soma_sched: directed sweeps plus randomized sweeps checked against
// an address-order model of issues and fired-spike output.
module tb_soma_sched;
  localparam int NNW = 12;
  localparam int SPK_DEPTH = 4;
  localparam int BUDGET = 400;

  logic           clk_soma = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable = 1'b1;
  logic           tick_start = 1'b0;
  logic           clear_mode = 1'b0;
  logic [NNW-1:0] neuron_last = '0;
  logic           axon_busy = 1'b0;
  logic           cfg_req = 1'b0;
  logic           cfg_gnt;
  logic           soma_spk_out_fire;
  logic           config_soma_vld;
  logic [NNW-1:0] config_soma_vm_addr;
  logic           config_soma_clear;
  logic           spk_vld;
  logic [NNW-1:0] spk_addr;
  logic           spk_rdy = 1'b1;
  logic           busy;
  logic           tick_done;
  logic           tick_overrun;

  int n_cmp = 0;
  int n_fail = 0;
  logic [NNW-1:0] exp_q[$];
  bit fire_pat [0:63];
  logic force_fire = 1'b0;
  logic noise_en = 1'b0;
  logic noise = 1'b0;
  logic vq = 1'b0;
  logic [NNW-1:0] aq = '0;

  always #5 clk_soma = ~clk_soma;

  soma_sched #(.NNW(NNW), .SPK_DEPTH(SPK_DEPTH)) dut (
    .clk_soma(clk_soma), .rst_n(rst_n), .enable(enable), .tick_start(tick_start),
    .clear_mode(clear_mode), .neuron_last(neuron_last), .axon_busy(axon_busy),
    .cfg_req(cfg_req), .cfg_gnt(cfg_gnt), .soma_spk_out_fire(soma_spk_out_fire),
    .config_soma_vld(config_soma_vld), .config_soma_vm_addr(config_soma_vm_addr),
    .config_soma_clear(config_soma_clear), .spk_vld(spk_vld), .spk_addr(spk_addr),
    .spk_rdy(spk_rdy), .busy(busy), .tick_done(tick_done), .tick_overrun(tick_overrun)
  );

  // Soma stand-in: the fire result follows a strobe by one cycle; otherwise noise.
  always @(posedge clk_soma) begin
    vq <= config_soma_vld;
    aq <= config_soma_vm_addr;
    noise <= noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
  end
  assign soma_spk_out_fire = vq ? (force_fire | fire_pat[aq[5:0]]) : noise;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_soma);
    #1;
  endtask

  task automatic drive(input int mode, input int c, input int issued, input int last);
    axon_busy = (mode == 2 && c >= 3 && c <= 6) || (mode == 3 && $urandom_range(0, 4) == 0);
    case (mode)
      1: spk_rdy = (c >= 30);
      3: spk_rdy = ($urandom_range(0, 3) != 0);
      default: spk_rdy = 1'b1;
    endcase
    cfg_req = (mode == 4 && (c <= 3 || c == 8)) ||
              (mode == 3 && c >= 1 && issued <= last && $urandom_range(0, 3) == 0);
  endtask

  task automatic check_pop(input int c, input int mode);
    logic [NNW-1:0] e;
    if (exp_q.size() == 0) begin
      chk("pop_without_expected_spike", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("spk_addr", 32'(spk_addr), 32'(e));
      if (mode == 0) chk("spk_pop_cycle", 32'(c), 32'(e) + 32'd3);
    end
  endtask

  // mode 0 plain, 1 backpressure, 2 axon stall, 3 random, 4 config defer, 5 overrun
  task automatic run_sweep(input int mode, input int last, input bit clr);
    int issued, first_c, exp_done, done_c;
    bit exact, prev_busy, exp_vld;
    exp_q.delete();
    for (int i = 0; i <= last; i++)
      if (!clr && (force_fire || fire_pat[i])) exp_q.push_back(NNW'(i));
    exact = (mode == 0 || mode == 2 || mode == 4 || mode == 5);
    first_c = (mode == 4) ? 5 : 1;
    exp_done = last + 3 + ((mode == 2 || mode == 4) ? 4 : 0);
    issued = 0;
    done_c = -1;
    noise_en = (mode == 3);
    tick_start = 1'b1;
    clear_mode = clr;
    neuron_last = NNW'(last);
    drive(mode, 0, 0, last);
    prev_busy = axon_busy;
    for (int c = 1; c <= BUDGET; c++) begin
      step();
      if (exact) begin
        exp_vld = (c >= first_c) && !prev_busy && (issued <= last);
        chk("vld_timing", 32'(config_soma_vld), 32'(exp_vld));
        chk("busy", 32'(busy), 32'((c >= first_c) && (c < exp_done)));
      end else if (config_soma_vld) begin
        chk("vld_after_axon_busy", 32'(prev_busy), 32'd0);
      end
      if (config_soma_vld) begin
        chk("vm_addr", 32'(config_soma_vm_addr), 32'(issued));
        chk("clear", 32'(config_soma_clear), 32'(clr));
        issued++;
      end
      chk("overrun", 32'(tick_overrun), 32'((mode == 4 && c == 3) || (mode == 5 && c == 4)));
      if (mode == 1 && c == 30) chk("issued_before_release", 32'(issued), 32'(SPK_DEPTH));
      if (!tick_done) begin
        tick_start = (mode == 4 && c == 2) || (mode == 5 && c == 3);
        if (mode != 4) begin
          clear_mode = 1'($urandom_range(0, 1));
          neuron_last = NNW'($urandom_range(0, 63));
        end
        drive(mode, c, issued, last);
      end
      if (spk_vld && spk_rdy) check_pop(c, mode);
      #1;
      if (exact) chk("cfg_gnt", 32'(cfg_gnt), 32'(cfg_req && (c < first_c || c >= exp_done)));
      else chk("cfg_gnt", 32'(cfg_gnt), 32'd0);
      if (tick_done) begin
        done_c = c;
        break;
      end
      prev_busy = axon_busy;
    end
    tick_start = 1'b0;
    noise_en = 1'b0;
    if (done_c < 0) chk("tick_done_timeout", 32'd0, 32'd1);
    else if (exact) chk("tick_done_cycle", 32'(done_c), 32'(exp_done));
    chk("issue_count", 32'(issued), 32'(last + 1));
    for (int k = 0; k < 64 && exp_q.size() != 0; k++) begin
      step();
      spk_rdy = 1'b1;
      axon_busy = 1'b0;
      cfg_req = 1'b0;
      if (spk_vld) check_pop(-1, -1);
    end
    chk("spikes_left", 32'(exp_q.size()), 32'd0);
    step();
    chk("fifo_empty_after", 32'(spk_vld), 32'd0);
    axon_busy = 1'b0;
    cfg_req = 1'b0;
    spk_rdy = 1'b1;
  endtask

  initial begin
    int last;
    bit clr;
    for (int i = 0; i < 64; i++) fire_pat[i] = 1'b0;
    #1;
    chk("rst_vld", 32'(config_soma_vld), 32'd0);
    chk("rst_addr", 32'(config_soma_vm_addr), 32'd0);
    chk("rst_clear", 32'(config_soma_clear), 32'd0);
    chk("rst_spk_vld", 32'(spk_vld), 32'd0);
    chk("rst_spk_addr", 32'(spk_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(tick_done), 32'd0);
    chk("rst_overrun", 32'(tick_overrun), 32'd0);
    chk("rst_cfg_gnt", 32'(cfg_gnt), 32'd0);
    #20 rst_n = 1'b1;
    step();

    // basic sweep: fires on 2 and 5
    fire_pat[2] = 1'b1;
    fire_pat[5] = 1'b1;
    run_sweep(0, 7, 1'b0);
    // clear sweep with fire forced high
    force_fire = 1'b1;
    run_sweep(0, 3, 1'b1);
    // backpressure, every neuron fires
    run_sweep(1, 15, 1'b0);
    force_fire = 1'b0;
    // axon stall, config deferral, overrun, single neuron
    for (int i = 0; i < 64; i++) fire_pat[i] = 1'($urandom_range(0, 1));
    run_sweep(2, 15, 1'b0);
    run_sweep(4, 5, 1'b0);
    run_sweep(5, 9, 1'b0);
    fire_pat[0] = 1'b1;
    run_sweep(0, 0, 1'b0);

    // randomized sweeps
    for (int r = 0; r < 8; r++) begin
      last = $urandom_range(0, 40);
      clr = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 64; i++) fire_pat[i] = ($urandom_range(0, 2) == 0);
      run_sweep(3, last, clr);
    end

    // abort mid-sweep
    force_fire = 1'b1;
    spk_rdy = 1'b0;
    tick_start = 1'b1;
    clear_mode = 1'b0;
    neuron_last = NNW'(20);
    step();
    tick_start = 1'b0;
    step();
    step();
    chk("abort_pre_busy", 32'(busy), 32'd1);
    chk("abort_pre_spk_vld", 32'(spk_vld), 32'd1);
    enable = 1'b0;
    step();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_vld", 32'(config_soma_vld), 32'd0);
    chk("abort_spk_vld", 32'(spk_vld), 32'd0);
    enable = 1'b1;
    spk_rdy = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("abort_no_vld", 32'(config_soma_vld), 32'd0);
      chk("abort_no_done", 32'(tick_done), 32'd0);
      chk("abort_no_spike", 32'(spk_vld), 32'd0);
    end

    // asynchronous reset mid-sweep
    tick_start = 1'b1;
    neuron_last = NNW'(20);
    step();
    tick_start = 1'b0;
    repeat (5) step();
    chk("pre_reset_spk_vld", 32'(spk_vld), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_vld", 32'(config_soma_vld), 32'd0);
    chk("areset_addr", 32'(config_soma_vm_addr), 32'd0);
    chk("areset_clear", 32'(config_soma_clear), 32'd0);
    chk("areset_spk_vld", 32'(spk_vld), 32'd0);
    chk("areset_spk_addr", 32'(spk_addr), 32'd0);
    chk("areset_busy", 32'(busy), 32'd0);
    chk("areset_done", 32'(tick_done), 32'd0);
    chk("areset_overrun", 32'(tick_overrun), 32'd0);
    chk("areset_cfg_gnt", 32'(cfg_gnt), 32'd0);
    step();
    rst_n = 1'b1;
    force_fire = 1'b0;
    step();
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("post_reset_vld", 32'(config_soma_vld), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
